// File: rtl/dac_hpf_multi_if.sv
// dac_hpf_multi_if: sample, control and result signals of the multi-channel DAC high-pass filter
interface dac_hpf_multi_if #(
  parameter int CH_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16
);
  logic hpf_en;
  logic [COEF_WIDTH-1:0] coef;
  logic clear_req;
  logic clear_busy;
  logic in_valid;
  logic in_ready;
  logic [CH_WIDTH-1:0] in_channel;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic [CH_WIDTH-1:0] out_channel;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic sat_flag;
  modport master (
    output hpf_en, coef, clear_req, in_valid, in_channel, in_data,
    input  clear_busy, in_ready, out_valid, out_channel, out_data, sat_flag
  );
  modport slave (
    input  hpf_en, coef, clear_req, in_valid, in_channel, in_data,
    output clear_busy, in_ready, out_valid, out_channel, out_data, sat_flag
  );
endinterface

// File: rtl/dac_hpf_multi.sv
// dac_hpf_multi: time-multiplexed first-order IIR high-pass filter with per-channel state and clear sequencer.
// Define HPF_SAT_EN to clamp the filtered output (and report it on sat_flag) instead of wrapping.
module dac_hpf_multi #(
  parameter int NUM_CHANNELS = 8,
  parameter int CH_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16
) (
  input logic dataclk,
  input logic reset,
  dac_hpf_multi_if.slave bus
);
  localparam int F = COEF_WIDTH;
  localparam int SW = DATA_WIDTH + F + 1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CH_WIDTH-1:0] cnt_q, cnt_d;
  logic signed [SW-1:0] st_q [NUM_CHANNELS];
  logic signed [SW-1:0] st_d [NUM_CHANNELS];
  logic pv_q, pv_d, pen_q, pen_d;
  logic [CH_WIDTH-1:0] pch_q, pch_d;
  logic [COEF_WIDTH-1:0] pcoef_q, pcoef_d;
  logic signed [DATA_WIDTH-1:0] px_q, px_d;
  logic signed [DATA_WIDTH:0] pe_q, pe_d;
  logic signed [SW-1:0] ps_q, ps_d;
  logic out_valid_q, out_valid_d, sat_q, sat_d;
  logic [CH_WIDTH-1:0] out_channel_q, out_channel_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic accept, last, wr;
  logic signed [SW-1:0] s_cur, s_next;
  logic signed [DATA_WIDTH-1:0] y_filt;
  always_ff @(posedge dataclk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    last = cnt_q == CH_WIDTH'(NUM_CHANNELS - 1);
    state_d = state_q == IDLE ? (bus.clear_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    cnt_d = state_q == CLEAR && !last ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    bus.clear_busy = state_q == CLEAR;
    bus.in_ready = state_q == IDLE;
    bus.out_valid = out_valid_q;
    bus.out_channel = out_channel_q;
    bus.out_data = out_data_q;
    bus.sat_flag = sat_q;
  end
  // A pending write-back is forwarded so back-to-back samples on one channel see the fresh state.
  always_comb begin
    accept = bus.in_valid && bus.in_ready;
    s_next = ps_q + SW'(pe_q) * SW'($signed({1'b0, pcoef_q}));
    wr = pv_q && !(state_q == CLEAR && pch_q <= cnt_q);
    s_cur = wr && pch_q == bus.in_channel ? s_next : st_q[bus.in_channel];
    pv_d = accept && 32'(bus.in_channel) < NUM_CHANNELS;
    pe_d = {bus.in_data[DATA_WIDTH-1], bus.in_data} - s_cur[SW-1:F];
    ps_d = s_cur;
    pch_d = bus.in_channel;
    pcoef_d = bus.coef;
    px_d = bus.in_data;
    pen_d = bus.hpf_en;
  end
  always_comb begin
    st_d = st_q;
    if (wr) st_d[pch_q] = s_next;
    if (state_q == CLEAR) st_d[cnt_q] = '0;
  end
  always_comb begin
`ifdef HPF_SAT_EN
    y_filt = pe_q[DATA_WIDTH] != pe_q[DATA_WIDTH-1]
      ? {pe_q[DATA_WIDTH], {(DATA_WIDTH-1){~pe_q[DATA_WIDTH]}}} : pe_q[DATA_WIDTH-1:0];
    sat_d = pv_q && pen_q && pe_q[DATA_WIDTH] != pe_q[DATA_WIDTH-1];
`else
    y_filt = pe_q[DATA_WIDTH-1:0];
    sat_d = 1'b0;
`endif
    out_valid_d = pv_q;
    out_channel_d = pch_q;
    out_data_d = pen_q ? y_filt : px_q;
  end
  always_ff @(posedge dataclk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) st_q[i] <= '0;
      pv_q <= 1'b0;
      pen_q <= 1'b0;
      pch_q <= '0;
      pcoef_q <= '0;
      px_q <= '0;
      pe_q <= '0;
      ps_q <= '0;
      out_valid_q <= 1'b0;
      out_channel_q <= '0;
      out_data_q <= '0;
      sat_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pv_q <= pv_d;
      pen_q <= pen_d;
      pch_q <= pch_d;
      pcoef_q <= pcoef_d;
      px_q <= px_d;
      pe_q <= pe_d;
      ps_q <= ps_d;
      out_valid_q <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_data_q <= out_data_d;
      sat_q <= sat_d;
    end
endmodule
